// File: rtl/piso_shift_transmitter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_transmitter_pkg
// Description : Shared constants and state encoding for the PISO transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_shift_transmitter_pkg;

    // Default serial word length in bits
    localparam int DEFAULT_WIDTH = 8;

    // Transmitter FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : piso_shift_transmitter_pkg
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : piso_bit_counter
// Description : Down counter tracking remaining bits of the word in flight.
//               Loads WIDTH-1, decrements on enable, holds at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_counter
    import piso_shift_transmitter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          dec_i,
    output logic          zero_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload wins over decrement; zero is a floor, never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o  = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule : piso_bit_counter
`default_nettype wire

// File: rtl/piso_shift_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_transmitter
// Description : Parallel-in serial-out transmitter, MSB first, with a
//               valid/ready load port supporting back-to-back words.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_transmitter
    import piso_shift_transmitter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             shift_out,
    output logic             shift_valid,
    output logic             last_bit
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CW-1:0]    cnt_value;
    logic             handshake;

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load),
        .dec_i   (cnt_dec),
        .zero_o  (cnt_zero),
        .count_o (cnt_value)
    );

    // Ready depends on registered state only, so load_valid never reaches it
    // through a loop; a word can be taken while the last bit is on the wire.
    assign load_ready = (state_q == ST_IDLE) || cnt_zero;
    assign handshake  = load_valid && load_ready;

    // Next-state, shift register update and counter control
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (handshake) begin
            state_d  = ST_SHIFT;
            shreg_d  = load_data;
            cnt_load = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_dec = 1'b1;
            if (cnt_zero) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State and shift register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    // Serial outputs decoded from registered state; forced low when idle
    always_comb begin
        shift_out   = 1'b0;
        shift_valid = 1'b0;
        last_bit    = 1'b0;
        if (state_q == ST_SHIFT) begin
            shift_out   = shreg_q[WIDTH-1];
            shift_valid = 1'b1;
            last_bit    = cnt_zero;
        end
    end

    // Count value is observable for debug only
    logic unused_cnt;
    assign unused_cnt = ^cnt_value;

endmodule : piso_shift_transmitter
`default_nettype wire
